alu_share_arbiter: RTL

- Shares one ALU instance between two requesters: port 0 is the execute-stage issue path, port 1 is the branch/address helper path.
- Arbitrates round-robin, registers the winning operands, and drives the ALU operand and control inputs for one cycle.
- Captures the ALU result and zero flag, then returns them on a single response channel tagged with the requester ID.
- Valid/ready handshakes on both sides; at most one operation is in flight.

---
 rtl/alu_share_arbiter_if.sv | 58 +++++
 rtl/alu_share_arbiter.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter_if.sv
// Bundles both requester channels, the ALU operand/result path and the tagged
// response channel shared by alu_share_arbiter.
interface alu_share_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [2:0]       req0_op;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [2:0]       req1_op;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_control;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero;
    logic             rsp_id;
    logic             rsp_illegal;

    logic             busy;

    // Arbiter side.
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req1_ready,
        output alu_a, alu_b, alu_control,
        input  alu_result, alu_zero,
        output rsp_valid, rsp_result, rsp_zero, rsp_id, rsp_illegal,
        input  rsp_ready,
        output busy
    );

    // Requester / ALU / consumer side.
    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req1_ready,
        input  alu_a, alu_b, alu_control,
        output alu_result, alu_zero,
        input  rsp_valid, rsp_result, rsp_zero, rsp_id, rsp_illegal,
        output rsp_ready,
        input  busy
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters, one
// operation in flight, result returned on a single response channel tagged by ID.
module alu_share_arbiter #(
    parameter int WIDTH    = 32,
    parameter bit CHECK_OP = 1'b1
) (
    input  logic               clk,
    input  logic               reset_n,
    alu_share_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [1:0]       req_valid;
    logic [WIDTH-1:0] req_a  [2];
    logic [WIDTH-1:0] req_b  [2];
    logic [2:0]       req_op [2];
    logic [1:0]       grant;
    logic [1:0]       grant_ready;

    logic             last_grant_q;
    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opb_q;
    logic [2:0]       opc_q;
    logic             opid_q;

    logic [WIDTH-1:0] rsp_result_q;
    logic             rsp_zero_q;
    logic             rsp_id_q;
    logic             rsp_illegal_q;

    logic accept;
    logic capture;
    logic win_id;
    logic op_illegal;

    assign req_valid = {bus.req1_valid, bus.req0_valid};
    assign req_a[0]  = bus.req0_a;
    assign req_a[1]  = bus.req1_a;
    assign req_b[0]  = bus.req0_b;
    assign req_b[1]  = bus.req1_b;
    assign req_op[0] = bus.req0_op;
    assign req_op[1] = bus.req1_op;

    // A port wins when it is alone, or on a tie when it was not granted last.
    // Ready is additionally masked by reset so nothing handshakes while held.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_grant
            assign grant[gi] = req_valid[gi] &
                               (~req_valid[1-gi] | (last_grant_q != 1'(gi)));
            assign grant_ready[gi] = grant[gi] & (state_q == ST_IDLE) & reset_n;
        end
    endgenerate

    assign bus.req0_ready = grant_ready[0];
    assign bus.req1_ready = grant_ready[1];
    assign win_id         = grant[1];

    always_comb begin
        op_illegal = 1'b0;
        if (CHECK_OP) begin
            case (opc_q)
                3'b010, 3'b110, 3'b000, 3'b001, 3'b111: op_illegal = 1'b0;
                default:                                op_illegal = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        accept        = 1'b0;
        capture       = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.busy      = 1'b1;
        case (state_q)
            ST_IDLE: begin
                bus.busy = 1'b0;
                if (|grant_ready) begin
                    accept  = 1'b1;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                capture = 1'b1;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= 1'b1;
            opa_q        <= '0;
            opb_q        <= '0;
            opc_q        <= '0;
            opid_q       <= 1'b0;
        end else if (accept) begin
            last_grant_q <= win_id;
            opa_q        <= req_a[win_id];
            opb_q        <= req_b[win_id];
            opc_q        <= req_op[win_id];
            opid_q       <= win_id;
        end
    end

    // An illegal code discards whatever the ALU produced for it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_result_q  <= '0;
            rsp_zero_q    <= 1'b0;
            rsp_id_q      <= 1'b0;
            rsp_illegal_q <= 1'b0;
        end else if (capture) begin
            rsp_result_q  <= op_illegal ? '0 : bus.alu_result;
            rsp_zero_q    <= op_illegal ? 1'b1 : bus.alu_zero;
            rsp_id_q      <= opid_q;
            rsp_illegal_q <= op_illegal;
        end
    end

    // ALU inputs come straight from the operand registers, so they only move
    // when a new operation is accepted.
    assign bus.alu_a       = opa_q;
    assign bus.alu_b       = opb_q;
    assign bus.alu_control = opc_q;

    assign bus.rsp_result  = rsp_result_q;
    assign bus.rsp_zero    = rsp_zero_q;
    assign bus.rsp_id      = rsp_id_q;
    assign bus.rsp_illegal = rsp_illegal_q;

endmodule
